uram_row_arbiter: RTL and testbench

- Row-level controller that shares one URAM port among NUM_CORES cores in a mini-row.
- Grants URAM access one core at a time with round-robin fairness, holding each grant while the owner's request stays high.
- Implements the row barrier: once every active core is locked, it requests an external drain, then broadcasts the emptied pulse that releases all cores.
- Sits between the per-core row-sync/URAM ports and the physical URAM.

---
 rtl/uram_row_arbiter_pkg.sv | 20 ++
 rtl/uram_row_arbiter_rr_priority_picker.sv | 41 ++++
 rtl/uram_row_arbiter.sv | 170 +++++++++++++++++
 tb/tb_uram_row_arbiter.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/uram_row_arbiter_pkg.sv
// Shared types and constants for the row-level URAM arbiter family.
// Latency: n/a (types, constants and a width helper only).
// Backpressure: n/a.
package uram_row_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_GRANT   = 2'd1,
        ST_DRAIN   = 2'd2,
        ST_RELEASE = 2'd3
    } uram_arb_state_t;

    localparam int MAX_HOLD_DEFAULT = 1024;

    // Width of a core index; never below 1 bit so single-bit rows still index cleanly.
    function automatic int core_idx_width(input int num_cores);
        return (num_cores > 1) ? $clog2(num_cores) : 1;
    endfunction

endpackage

// File: rtl/uram_row_arbiter_rr_priority_picker.sv
// Round-robin picker: first set request at or after the pointer, wrapping around.
// Latency: purely combinational.
// Backpressure: none; the caller decides when to register the pick.
module rr_priority_picker
    import uram_row_arbiter_pkg::*;
#(
    parameter int N = 8
) (
    input  logic [N-1:0]                 req_i,
    input  logic [core_idx_width(N)-1:0] ptr_i,
    output logic [N-1:0]                 grant_o,
    output logic [core_idx_width(N)-1:0] idx_o,
    output logic                         any_o
);

    localparam int IW = core_idx_width(N);

    // Scan from the pointer upwards, wrapping at N, and stop at the first hit.
    always_comb begin
        int                c;
        logic [IW-1:0]     cidx;
        grant_o = '0;
        idx_o   = '0;
        any_o   = 1'b0;
        c       = 0;
        cidx    = '0;
        for (int k = 0; k < N; k++) begin
            c = int'(ptr_i) + k;
            if (c >= N) begin
                c = c - N;
            end
            cidx = IW'(c);
            if (!any_o && req_i[cidx]) begin
                any_o         = 1'b1;
                grant_o[cidx] = 1'b1;
                idx_o         = cidx;
            end
        end
    end

endmodule

// File: rtl/uram_row_arbiter.sv
// Shares one URAM port among the cores of a row (round-robin) and runs the row barrier/drain.
// Latency: request to grant 1 cycle; granted core's URAM inputs reach the URAM 1 cycle later.
// Backpressure: a grant is held while its owner requests; others wait; forced revoke after MAX_HOLD cycles.
module uram_row_arbiter
    import uram_row_arbiter_pkg::*;
#(
    parameter int                   NUM_CORES   = 8,
    parameter int                   ADDR_WIDTH  = 12,
    parameter int                   DATA_WIDTH  = 32,
    parameter logic [NUM_CORES-1:0] ACTIVE_MASK = {NUM_CORES{1'b1}},
    parameter int                   MAX_HOLD    = MAX_HOLD_DEFAULT
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic [NUM_CORES-1:0]            i_core_req,
    input  logic [NUM_CORES-1:0]            i_core_locked,
    output logic [NUM_CORES-1:0]            o_core_grant,
    input  logic [NUM_CORES-1:0]            i_core_uram_en,
    input  logic [NUM_CORES*ADDR_WIDTH-1:0] i_core_uram_addr,
    input  logic [NUM_CORES*DATA_WIDTH-1:0] i_core_uram_wr_data,
    input  logic [NUM_CORES-1:0]            i_core_uram_wr_en,
    output logic                            o_uram_en,
    output logic [ADDR_WIDTH-1:0]           o_uram_addr,
    output logic [DATA_WIDTH-1:0]           o_uram_wr_data,
    output logic                            o_uram_wr_en,
    output logic                            o_drain_req,
    input  logic                            i_drain_done,
    output logic                            o_uram_emptied,
    output logic                            o_err_timeout
);

    localparam int IDX_W  = core_idx_width(NUM_CORES);
    localparam int HOLD_W = (MAX_HOLD > 2) ? $clog2(MAX_HOLD) : 1;

    uram_arb_state_t        state_q, state_d;
    logic [NUM_CORES-1:0]   grant_q, grant_d;
    logic [IDX_W-1:0]       owner_q, owner_d;
    logic [IDX_W-1:0]       ptr_q, ptr_d;
    logic [HOLD_W-1:0]      hold_q, hold_d;
    logic                   err_q, err_d;
    logic                   uram_en_q, uram_en_d;
    logic [ADDR_WIDTH-1:0]  uram_addr_q, uram_addr_d;
    logic [DATA_WIDTH-1:0]  uram_wr_data_q, uram_wr_data_d;
    logic                   uram_wr_en_q, uram_wr_en_d;

    logic [NUM_CORES-1:0]   eligible;
    logic                   barrier;
    logic [NUM_CORES-1:0]   pick_grant;
    logic [IDX_W-1:0]       pick_idx;
    logic                   pick_any;
    logic                   keep_grant;
    logic [IDX_W-1:0]       owner_next_ptr;

    assign eligible       = i_core_req & ~i_core_locked & ACTIVE_MASK;
    assign barrier        = &(i_core_locked | ~ACTIVE_MASK);
    assign owner_next_ptr = (owner_q == IDX_W'(NUM_CORES - 1)) ? '0 : owner_q + IDX_W'(1);

    rr_priority_picker #(
        .N (NUM_CORES)
    ) u_picker (
        .req_i   (eligible),
        .ptr_i   (ptr_q),
        .grant_o (pick_grant),
        .idx_o   (pick_idx),
        .any_o   (pick_any)
    );

    // FSM next state: barrier beats arbitration in IDLE; a grant ends on release or hold timeout.
    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        owner_d    = owner_q;
        ptr_d      = ptr_q;
        hold_d     = hold_q;
        err_d      = err_q;
        keep_grant = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (barrier) begin
                    state_d = ST_DRAIN;
                end else if (pick_any) begin
                    state_d = ST_GRANT;
                    grant_d = pick_grant;
                    owner_d = pick_idx;
                    hold_d  = '0;
                end
            end
            ST_GRANT: begin
                if (!i_core_req[owner_q] || i_core_locked[owner_q]) begin
                    state_d = ST_IDLE;
                    grant_d = '0;
                    ptr_d   = owner_next_ptr;
                    hold_d  = '0;
                end else if (hold_q == HOLD_W'(MAX_HOLD - 1)) begin
                    state_d = ST_IDLE;
                    grant_d = '0;
                    ptr_d   = owner_next_ptr;
                    hold_d  = '0;
                    err_d   = 1'b1;
                end else begin
                    hold_d     = hold_q + HOLD_W'(1);
                    keep_grant = 1'b1;
                end
            end
            ST_DRAIN: begin
                if (i_drain_done) begin
                    state_d = ST_RELEASE;
                end
            end
            ST_RELEASE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
                grant_d = '0;
            end
        endcase
    end

    // URAM datapath: copy the owner's port only while the grant survives into the next cycle.
    always_comb begin
        uram_en_d      = 1'b0;
        uram_addr_d    = '0;
        uram_wr_data_d = '0;
        uram_wr_en_d   = 1'b0;
        if (keep_grant) begin
            uram_en_d      = i_core_uram_en[owner_q];
            uram_addr_d    = i_core_uram_addr[owner_q*ADDR_WIDTH +: ADDR_WIDTH];
            uram_wr_data_d = i_core_uram_wr_data[owner_q*DATA_WIDTH +: DATA_WIDTH];
            uram_wr_en_d   = i_core_uram_wr_en[owner_q];
        end
    end

    // State, pointer, counter and datapath registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q        <= ST_IDLE;
            grant_q        <= '0;
            owner_q        <= '0;
            ptr_q          <= '0;
            hold_q         <= '0;
            err_q          <= 1'b0;
            uram_en_q      <= 1'b0;
            uram_addr_q    <= '0;
            uram_wr_data_q <= '0;
            uram_wr_en_q   <= 1'b0;
        end else begin
            state_q        <= state_d;
            grant_q        <= grant_d;
            owner_q        <= owner_d;
            ptr_q          <= ptr_d;
            hold_q         <= hold_d;
            err_q          <= err_d;
            uram_en_q      <= uram_en_d;
            uram_addr_q    <= uram_addr_d;
            uram_wr_data_q <= uram_wr_data_d;
            uram_wr_en_q   <= uram_wr_en_d;
        end
    end

    assign o_core_grant   = grant_q;
    assign o_drain_req    = (state_q == ST_DRAIN);
    assign o_uram_emptied = (state_q == ST_RELEASE);
    assign o_err_timeout  = err_q;
    assign o_uram_en      = uram_en_q;
    assign o_uram_addr    = uram_addr_q;
    assign o_uram_wr_data = uram_wr_data_q;
    assign o_uram_wr_en   = uram_wr_en_q;

endmodule

// File: tb/tb_uram_row_arbiter.sv
// Bench for the row URAM arbiter: directed scenarios plus random traffic against a behavioural model.
// Latency: expected outputs are queued per clock edge and compared on the following falling edge.
// Backpressure: n/a.
module tb_uram_row_arbiter;

    localparam int        N    = 4;
    localparam int        AW   = 12;
    localparam int        DW   = 32;
    localparam int        MAXH = 8;
    localparam logic [3:0] MASK = 4'b1111;

    logic            clk;
    logic            rst_n;
    logic [N-1:0]    req, locked, en, wr_en;
    logic [N*AW-1:0] addr;
    logic [N*DW-1:0] data;
    logic            drain_done;
    logic [N-1:0]    o_core_grant;
    logic            o_uram_en, o_uram_wr_en, o_drain_req, o_uram_emptied, o_err_timeout;
    logic [AW-1:0]   o_uram_addr;
    logic [DW-1:0]   o_uram_wr_data;

    uram_row_arbiter #(
        .NUM_CORES   (N),
        .ADDR_WIDTH  (AW),
        .DATA_WIDTH  (DW),
        .ACTIVE_MASK (MASK),
        .MAX_HOLD    (MAXH)
    ) dut (
        .clk                 (clk),
        .reset               (rst_n),
        .i_core_req          (req),
        .i_core_locked       (locked),
        .o_core_grant        (o_core_grant),
        .i_core_uram_en      (en),
        .i_core_uram_addr    (addr),
        .i_core_uram_wr_data (data),
        .i_core_uram_wr_en   (wr_en),
        .o_uram_en           (o_uram_en),
        .o_uram_addr         (o_uram_addr),
        .o_uram_wr_data      (o_uram_wr_data),
        .o_uram_wr_en        (o_uram_wr_en),
        .o_drain_req         (o_drain_req),
        .i_drain_done        (drain_done),
        .o_uram_emptied      (o_uram_emptied),
        .o_err_timeout       (o_err_timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [N-1:0] grant;
        logic         drain;
        logic         emptied;
        logic         err;
        logic [45:0]  uram;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    // Behavioural model: who owns the port, how long, and which barrier phase the row is in.
    int   m_owner = -1;
    int   m_ptr   = 0;
    int   m_held  = 0;
    bit   m_drain = 0;
    bit   m_rel   = 0;
    bit   m_err   = 0;
    logic [45:0] m_uram = '0;

    // Recording of DUT grant order for the round-robin scenario.
    bit   rr_rec = 0;
    int   rr_seen[$];
    logic [N-1:0] prev_grant = '0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Model update on every rising edge; pushes the outputs the DUT must show for the next cycle.
    initial forever begin
        @(posedge clk);
        begin
            exp_t e;
            int   o;
            logic [N-1:0] elig;
            elig = req & ~locked & MASK;
            if (!rst_n) begin
                m_owner = -1; m_ptr = 0; m_held = 0;
                m_drain = 0;  m_rel = 0; m_err  = 0;
                m_uram  = '0;
            end else begin
                m_uram = '0;
                if (m_owner >= 0) begin
                    o = m_owner;
                    if (!req[o] || locked[o] || m_held == MAXH - 1) begin
                        if (req[o] && !locked[o]) m_err = 1;
                        m_ptr   = (o + 1) % N;
                        m_owner = -1;
                        m_held  = 0;
                    end else begin
                        m_held++;
                        m_uram = {en[o], wr_en[o], addr[o*AW +: AW], data[o*DW +: DW]};
                    end
                end else if (m_drain) begin
                    if (drain_done) begin
                        m_drain = 0;
                        m_rel   = 1;
                    end
                end else if (m_rel) begin
                    m_rel = 0;
                end else if (&(locked | ~MASK)) begin
                    m_drain = 1;
                end else begin
                    for (int k = 0; k < N; k++) begin
                        if (m_owner < 0 && elig[(m_ptr + k) % N]) begin
                            m_owner = (m_ptr + k) % N;
                            m_held  = 0;
                        end
                    end
                end
            end
            e.grant   = (m_owner >= 0) ? N'(1 << m_owner) : '0;
            e.drain   = m_drain;
            e.emptied = m_rel;
            e.err     = m_err;
            e.uram    = m_uram;
            exp_q.push_back(e);
        end
    end

    // Monitor: pops one expectation per cycle and compares it away from the active edge.
    initial forever begin
        @(negedge clk);
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            chk("grant",   64'(o_core_grant),   64'(e.grant));
            chk("drain_req", 64'(o_drain_req),  64'(e.drain));
            chk("emptied", 64'(o_uram_emptied), 64'(e.emptied));
            chk("err_timeout", 64'(o_err_timeout), 64'(e.err));
            chk("uram_port", 64'({o_uram_en, o_uram_wr_en, o_uram_addr, o_uram_wr_data}), 64'(e.uram));
        end
        if (rr_rec && o_core_grant != '0 && prev_grant == '0) begin
            for (int k = 0; k < N; k++) begin
                if (o_core_grant[k]) rr_seen.push_back(k);
            end
        end
        prev_grant = o_core_grant;
    end

    initial begin
        int rr_exp [5];
        int r;
        rr_exp = '{0, 1, 2, 3, 0};

        // Reset held with random inputs, then quiet.
        rst_n = 1'b0;
        req = 4'($urandom); locked = 4'($urandom); en = 4'($urandom); wr_en = 4'($urandom);
        addr = 48'({$urandom, $urandom}); data = {$urandom, $urandom, $urandom, $urandom};
        drain_done = 1'($urandom);
        step(3);
        rst_n = 1'b1; req = '0; locked = '0; en = '0; wr_en = '0; drain_done = 1'b0;
        addr = '0; data = '0;
        step(3);

        // Single requester with a write on core 2.
        req = 4'b0100; en = 4'b0100; wr_en = 4'b0100;
        addr[2*AW +: AW] = 12'h0A5; data[2*DW +: DW] = 32'hDEADBEEF;
        step(4);
        req = '0;
        step(3);

        // Round-robin: every core keeps asking and backs off a few cycles into its own grant.
        rst_n = 1'b0; step(2); rst_n = 1'b1;
        rr_rec = 1;
        req = 4'hF;
        repeat (30) begin
            step(1);
            for (int c = 0; c < N; c++) req[c] = !(m_owner == c && m_held >= 2);
        end
        rr_rec = 0;
        req = '0;
        step(3);
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (i >= rr_seen.size() || rr_seen[i] != rr_exp[i]) begin
                errors++;
                $display("FAIL rr_order[%0d]: got %0d expected %0d", i,
                         (i < rr_seen.size()) ? rr_seen[i] : -1, rr_exp[i]);
            end
        end

        // Barrier: locks arrive one by one while cores 0/1 request, then drain and release.
        req = 4'b0011;
        locked = 4'b0001; step(1);
        locked = 4'b0011; step(1);
        locked = 4'b0111; step(1);
        locked = 4'b1111; step(4);
        drain_done = 1'b1; step(1);
        drain_done = 1'b0; step(2);
        locked = '0; step(6);
        req = '0; step(2);

        // Timeout: core 1 never lets go, core 2 waits behind it.
        rst_n = 1'b0; step(1); rst_n = 1'b1;
        req = 4'b0110;
        step(24);
        req = '0;
        step(3);

        // Reset in the middle of a drain.
        locked = 4'hF; step(4);
        rst_n = 1'b0; step(1);
        locked = '0; req = 4'hF; rst_n = 1'b1;
        step(3);
        req = '0; step(3);

        // Random traffic.
        repeat (2000) begin
            r = $urandom_range(0, 7);
            req    = 4'($urandom);
            locked = (r == 0) ? 4'hF : 4'($urandom & $urandom);
            en     = 4'($urandom);
            wr_en  = 4'($urandom);
            addr   = 48'({$urandom, $urandom});
            data   = {$urandom, $urandom, $urandom, $urandom};
            drain_done = ($urandom_range(0, 3) == 0);
            rst_n  = ($urandom_range(0, 199) != 0);
            step(1);
        end
        rst_n = 1'b1; req = '0; locked = '0; drain_done = 1'b0;
        step(4);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
